// File: rtl/timer_sequencer.sv
// Countdown timer sequencer: MM:SS set in IDLE, counted down on tick_1hz, blinks in DONE then restores preset.
// Optional build macro TIMER_AUTOREPEAT_EN adds tick-paced repeat stepping for held set buttons in IDLE.
//
// state | meaning
// IDLE  | count editable with increase/decrease, start arms a run
// RUN   | count decrements once per tick_1hz
// PAUSE | count frozen until the next start press
// DONE  | count at 00:00, blink_en high, returns to IDLE with preset
module timer_sequencer #(
    parameter int BLINK_SECS = 10
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       set_time_increase,
    input  logic       set_time_decrease,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] Countmin,
    output logic [7:0] Countsec,
    output logic [1:0] state,
    output logic       done_pulse,
    output logic       blink_en
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] preset_q, preset_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        done_pulse_q, done_pulse_d;
    logic        blink_en_q, blink_en_d;
    logic [3:0]  btn_prev_q;
    logic [3:0]  btn_now;
    logic [3:0]  btn_edge;
    logic        ev_start, ev_pause, ev_inc, ev_dec;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = {4'(v[7:4] + 4'd1), 4'd0};
        else                r = {v[7:4], 4'(v[3:0] + 4'd1)};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) r = {4'(v[7:4] - 4'd1), 4'd9};
        else                r = {v[7:4], 4'(v[3:0] - 4'd1)};
        return r;
    endfunction

    // Both helpers saturate at the ends of the 00:00..99:59 range.
    function automatic logic [15:0] mmss_inc(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[7:0] == 8'h59) begin
            if (t[15:8] != 8'h99) r = {bcd_inc(t[15:8]), 8'h00};
        end else begin
            r = {t[15:8], bcd_inc(t[7:0])};
        end
        return r;
    endfunction

    function automatic logic [15:0] mmss_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[7:0] == 8'h00) begin
            if (t[15:8] != 8'h00) r = {bcd_dec(t[15:8]), 8'h59};
        end else begin
            r = {t[15:8], bcd_dec(t[7:0])};
        end
        return r;
    endfunction

    assign btn_now  = {start, pause, set_time_increase, set_time_decrease};
    assign btn_edge = btn_now & ~btn_prev_q;

    // Strict priority: a higher edge swallows all lower edges of the same cycle.
    assign ev_start = btn_edge[3];
    assign ev_pause = btn_edge[2] & ~btn_edge[3];
    assign ev_inc   = btn_edge[1] & ~|btn_edge[3:2];
    assign ev_dec   = btn_edge[0] & ~|btn_edge[3:1];

`ifdef TIMER_AUTOREPEAT_EN
    logic       rep_act_q, rep_act_d;
    logic       rep_dir_q, rep_dir_d;
    logic [1:0] rep_wait_q, rep_wait_d;
    logic       rep_held;
    logic       rep_step;

    assign rep_held = rep_dir_q ? set_time_increase : set_time_decrease;

    // Repeat waits out two ticks after the press, then steps on every tick while held.
    always_comb begin
        rep_act_d  = rep_act_q;
        rep_dir_d  = rep_dir_q;
        rep_wait_d = rep_wait_q;
        rep_step   = 1'b0;
        if (rep_act_q && rep_held && state_q == S_IDLE && tick_1hz &&
            !(ev_start || ev_pause || ev_inc || ev_dec)) begin
            if (rep_wait_q != 2'd0) rep_wait_d = rep_wait_q - 2'd1;
            else                    rep_step   = 1'b1;
        end
        if (!rep_held || state_q != S_IDLE) rep_act_d = 1'b0;
        if (state_q == S_IDLE && (ev_inc || ev_dec)) begin
            rep_act_d  = 1'b1;
            rep_dir_d  = ev_inc;
            rep_wait_d = 2'd2;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rep_act_q  <= 1'b0;
            rep_dir_q  <= 1'b0;
            rep_wait_q <= 2'd0;
        end else begin
            rep_act_q  <= rep_act_d;
            rep_dir_q  <= rep_dir_d;
            rep_wait_q <= rep_wait_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        preset_d     = preset_q;
        blink_cnt_d  = blink_cnt_q;
        done_pulse_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ev_start) begin
                    if (cnt_q != 16'h0000) begin
                        preset_d = cnt_q;
                        state_d  = S_RUN;
                    end
                end else if (ev_inc) begin
                    cnt_d = mmss_inc(cnt_q);
                end else if (ev_dec) begin
                    cnt_d = mmss_dec(cnt_q);
`ifdef TIMER_AUTOREPEAT_EN
                end else if (rep_step) begin
                    cnt_d = rep_dir_q ? mmss_inc(cnt_q) : mmss_dec(cnt_q);
`endif
                end
            end
            S_RUN: begin
                if (ev_pause) begin
                    state_d = S_PAUSE;
                end else if (tick_1hz) begin
                    cnt_d = mmss_dec(cnt_q);
                    if (mmss_dec(cnt_q) == 16'h0000) begin
                        state_d      = S_DONE;
                        done_pulse_d = 1'b1;
                        blink_cnt_d  = 8'(BLINK_SECS);
                    end
                end
            end
            S_PAUSE: begin
                if (ev_start) state_d = S_RUN;
            end
            S_DONE: begin
                if (ev_start) begin
                    cnt_d       = preset_q;
                    blink_cnt_d = 8'd0;
                    state_d     = S_IDLE;
                end else if (tick_1hz) begin
                    if (blink_cnt_q <= 8'd1) begin
                        cnt_d       = preset_q;
                        blink_cnt_d = 8'd0;
                        state_d     = S_IDLE;
                    end else begin
                        blink_cnt_d = blink_cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        blink_en_d = (state_d == S_DONE);
    end

    // History loads all-ones in reset so buttons held across reset release stay silent.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'h0000;
            preset_q     <= 16'h0000;
            blink_cnt_q  <= 8'd0;
            done_pulse_q <= 1'b0;
            blink_en_q   <= 1'b0;
            btn_prev_q   <= 4'hF;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            preset_q     <= preset_d;
            blink_cnt_q  <= blink_cnt_d;
            done_pulse_q <= done_pulse_d;
            blink_en_q   <= blink_en_d;
            btn_prev_q   <= btn_now;
        end
    end

    assign Countmin   = cnt_q[15:8];
    assign Countsec   = cnt_q[7:0];
    assign state      = state_q;
    assign done_pulse = done_pulse_q;
    assign blink_en   = blink_en_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer: directed scenarios plus random stimulus against a seconds-based model.
module tb_timer_sequencer;

    logic       sys_clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       inc_b = 1'b0;
    logic       dec_b = 1'b0;
    logic       start_b = 1'b0;
    logic       pause_b = 1'b0;
    logic [7:0] Countmin, Countsec;
    logic [1:0] state;
    logic       done_pulse, blink_en;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: count kept as total seconds.
    int       m_state, m_total, m_preset, m_blink;
    bit       m_pulse;
    bit [3:0] m_prev;

    timer_sequencer #(.BLINK_SECS(10)) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .tick_1hz(tick_1hz),
        .set_time_increase(inc_b),
        .set_time_decrease(dec_b),
        .start(start_b),
        .pause(pause_b),
        .Countmin(Countmin),
        .Countsec(Countsec),
        .state(state),
        .done_pulse(done_pulse),
        .blink_en(blink_en)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_step(input bit r, input bit st, input bit pa, input bit in, input bit de, input bit tk);
        bit es, ep, ei, ed;
        if (r) begin
            m_state = 0; m_total = 0; m_preset = 0; m_blink = 0; m_pulse = 0; m_prev = 4'hF;
            return;
        end
        es = st && !m_prev[3];
        ep = pa && !m_prev[2];
        ei = in && !m_prev[1];
        ed = de && !m_prev[0];
        m_prev = {st, pa, in, de};
        if (es) begin ep = 0; ei = 0; ed = 0; end
        else if (ep) begin ei = 0; ed = 0; end
        else if (ei) ed = 0;
        m_pulse = 0;
        case (m_state)
            0: begin
                if (es) begin
                    if (m_total > 0) begin m_preset = m_total; m_state = 1; end
                end else if (ei) begin
                    if (m_total < 99 * 60 + 59) m_total++;
                end else if (ed) begin
                    if (m_total > 0) m_total--;
                end
            end
            1: begin
                if (ep) m_state = 2;
                else if (tk) begin
                    m_total--;
                    if (m_total == 0) begin m_state = 3; m_pulse = 1; m_blink = 0; end
                end
            end
            2: if (es) m_state = 1;
            default: begin
                if (es) begin m_total = m_preset; m_state = 0; end
                else if (tk) begin
                    m_blink++;
                    if (m_blink == 10) begin m_total = m_preset; m_state = 0; end
                end
            end
        endcase
    endtask

    task automatic cyc(input bit r, input bit st, input bit pa, input bit in, input bit de, input bit tk);
        reset = r; start_b = st; pause_b = pa; inc_b = in; dec_b = de; tick_1hz = tk;
        model_step(r, st, pa, in, de, tk);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    // b: 0 start, 1 pause, 2 increase, 3 decrease
    task automatic press(input int b, input int n);
        for (int k = 0; k < n; k++) begin
            cyc(0, b == 0, b == 1, b == 2, b == 3, 0);
            cyc(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 0);
        if ({Countmin, Countsec} !== 16'h0000) begin n_bad++; $display("FAIL reset_count got=%h exp=0000", {Countmin, Countsec}); end
        n_cmp++;
        if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_cmp++;
        if ({done_pulse, blink_en} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got=%b exp=00", {done_pulse, blink_en}); end
        n_cmp++;
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_set_time();
        do_reset();
        press(2, 61);
        if ({Countmin, Countsec} !== 16'h0101) begin n_bad++; $display("FAIL set_inc61 got=%h exp=0101", {Countmin, Countsec}); end
        n_cmp++;
        if (state !== 2'd0) begin n_bad++; $display("FAIL set_state got=%0d exp=0", state); end
        n_cmp++;
        press(3, 2);
        if ({Countmin, Countsec} !== 16'h0059) begin n_bad++; $display("FAIL set_dec2 got=%h exp=0059", {Countmin, Countsec}); end
        n_cmp++;
        // a held level must step only once
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        if ({Countmin, Countsec} !== 16'h0100) begin n_bad++; $display("FAIL set_held got=%h exp=0100", {Countmin, Countsec}); end
        n_cmp++;
    endtask

    task automatic test_run_done();
        do_reset();
        press(2, 3);
        press(0, 1);
        if (state !== 2'd1) begin n_bad++; $display("FAIL run_enter got=%0d exp=1", state); end
        n_cmp++;
        for (int k = 2; k >= 0; k--) begin
            cyc(0, 0, 0, 0, 0, 1);
            if (Countsec !== to_bcd(k)) begin n_bad++; $display("FAIL run_tick got=%h exp=%h", Countsec, to_bcd(k)); end
            n_cmp++;
            if (done_pulse !== (k == 0)) begin n_bad++; $display("FAIL run_pulse got=%b exp=%b", done_pulse, k == 0); end
            n_cmp++;
        end
        if ({state, blink_en} !== 3'b111) begin n_bad++; $display("FAIL done_state got=%b exp=111", {state, blink_en}); end
        n_cmp++;
        press(2, 1);
        if ({Countmin, Countsec, done_pulse} !== 17'h0) begin n_bad++; $display("FAIL done_hold got=%h exp=0", {Countmin, Countsec, done_pulse}); end
        n_cmp++;
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0, 0, 0, 1);
            if (k == 9 && state !== 2'd3) begin n_bad++; $display("FAIL done_early got=%0d exp=3", state); end
            if (k == 9) n_cmp++;
        end
        if ({state, blink_en} !== 3'b000) begin n_bad++; $display("FAIL done_exit got=%b exp=000", {state, blink_en}); end
        n_cmp++;
        if ({Countmin, Countsec} !== 16'h0003) begin n_bad++; $display("FAIL done_reload got=%h exp=0003", {Countmin, Countsec}); end
        n_cmp++;
    endtask

    task automatic test_pause();
        do_reset();
        press(2, 60);
        press(0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        if ({state, Countmin, Countsec} !== {2'd2, 16'h0100}) begin n_bad++; $display("FAIL pause_enter got=%0d %h exp=2 0100", state, {Countmin, Countsec}); end
        n_cmp++;
        cyc(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0, 1);
        press(2, 1);
        press(3, 1);
        if ({state, Countmin, Countsec} !== {2'd2, 16'h0100}) begin n_bad++; $display("FAIL pause_frozen got=%0d %h exp=2 0100", state, {Countmin, Countsec}); end
        n_cmp++;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        if ({state, Countmin, Countsec} !== {2'd1, 16'h0100}) begin n_bad++; $display("FAIL pause_resume got=%0d %h exp=1 0100", state, {Countmin, Countsec}); end
        n_cmp++;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        if ({Countmin, Countsec} !== 16'h0059) begin n_bad++; $display("FAIL pause_tick got=%h exp=0059", {Countmin, Countsec}); end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        press(2, 62);
        press(0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        if ({Countmin, Countsec} !== 16'h0059) begin n_bad++; $display("FAIL b2b_borrow got=%h exp=0059", {Countmin, Countsec}); end
        n_cmp++;
    endtask

    task automatic test_limits();
        do_reset();
        press(2, 5999);
        if ({Countmin, Countsec} !== 16'h9959) begin n_bad++; $display("FAIL lim_max got=%h exp=9959", {Countmin, Countsec}); end
        n_cmp++;
        press(2, 1);
        if ({Countmin, Countsec} !== 16'h9959) begin n_bad++; $display("FAIL lim_inc_sat got=%h exp=9959", {Countmin, Countsec}); end
        n_cmp++;
        do_reset();
        press(3, 1);
        press(0, 1);
        if ({state, Countmin, Countsec} !== 18'h0) begin n_bad++; $display("FAIL lim_zero got=%h exp=0", {state, Countmin, Countsec}); end
        n_cmp++;
        press(2, 5);
        cyc(0, 1, 0, 1, 0, 0);
        if ({state, Countmin, Countsec} !== {2'd1, 16'h0005}) begin n_bad++; $display("FAIL lim_prio got=%0d %h exp=1 0005", state, {Countmin, Countsec}); end
        n_cmp++;
    endtask

    task automatic test_reset_override();
        cyc(1, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        if ({state, Countmin, Countsec} !== 18'h0) begin n_bad++; $display("FAIL rst_held got=%h exp=0", {state, Countmin, Countsec}); end
        n_cmp++;
        cyc(0, 0, 0, 0, 0, 0);
        press(2, 42);
        press(0, 1);
        if ({state, Countmin, Countsec} !== {2'd1, 16'h0042}) begin n_bad++; $display("FAIL rst_run got=%0d %h exp=1 0042", state, {Countmin, Countsec}); end
        n_cmp++;
        cyc(1, 0, 1, 0, 0, 1);
        if ({state, Countmin, Countsec} !== 18'h0) begin n_bad++; $display("FAIL rst_midrun got=%h exp=0", {state, Countmin, Countsec}); end
        n_cmp++;
        cyc(0, 0, 0, 0, 0, 0);
        press(2, 1);
        press(0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 1);
        if ({state, Countmin, Countsec, blink_en, done_pulse} !== 20'h0) begin n_bad++; $display("FAIL rst_middone got=%h exp=0", {state, Countmin, Countsec, blink_en, done_pulse}); end
        n_cmp++;
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_autorepeat();
        logic [15:0] exp_cnt;
`ifdef TIMER_AUTOREPEAT_EN
        exp_cnt = 16'h0004;
`else
        exp_cnt = 16'h0001;
`endif
        do_reset();
        cyc(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 1, 0, 1);
            cyc(0, 0, 0, 1, 0, 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        if ({Countmin, Countsec} !== exp_cnt) begin n_bad++; $display("FAIL autorep got=%h exp=%h", {Countmin, Countsec}, exp_cnt); end
        n_cmp++;
    endtask

    // Buttons are single-cycle presses so auto-repeat never engages here.
    task automatic test_random();
        bit r, s, p, i, d, t;
        bit ps, pp, pi, pd;
        ps = 0; pp = 0; pi = 0; pd = 0;
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            r = ($urandom_range(0, 599) == 0);
            s = !ps && ($urandom_range(0, 7) == 0);
            p = !pp && ($urandom_range(0, 9) == 0);
            i = !pi && ($urandom_range(0, 2) == 0);
            d = !pd && ($urandom_range(0, 4) == 0);
            t = ($urandom_range(0, 2) == 0);
            ps = s; pp = p; pi = i; pd = d;
            cyc(r, s, p, i, d, t);
            if (Countmin !== to_bcd(m_total / 60)) begin n_bad++; $display("FAIL rnd_min cyc=%0d got=%h exp=%h", k, Countmin, to_bcd(m_total / 60)); end
            n_cmp++;
            if (Countsec !== to_bcd(m_total % 60)) begin n_bad++; $display("FAIL rnd_sec cyc=%0d got=%h exp=%h", k, Countsec, to_bcd(m_total % 60)); end
            n_cmp++;
            if (state !== 2'(m_state)) begin n_bad++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", k, state, m_state); end
            n_cmp++;
            if (done_pulse !== m_pulse) begin n_bad++; $display("FAIL rnd_pulse cyc=%0d got=%b exp=%b", k, done_pulse, m_pulse); end
            n_cmp++;
            if (blink_en !== (m_state == 3)) begin n_bad++; $display("FAIL rnd_blink cyc=%0d got=%b exp=%b", k, blink_en, m_state == 3); end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_set_time();
        test_run_done();
        test_pause();
        test_back_to_back();
        test_limits();
        test_reset_override();
        test_autorepeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
